ram_port_arbiter: RTL and testbench

Shares the single-port on-chip RAM between two requesters: m0 (instruction fetch) and m1 (load/store unit). The arbiter admits at most one RAM access per cycle and breaks conflicts with round-robin. It returns the RAM's registered read data to the winning requester one cycle later, together with an acknowledge. It sits between the CPU memory ports and the on-chip RAM, which has an 8192×32 array, a 13-bit word address, byte enables and 1-cycle registered read data.

---
 rtl/ram_port_arbiter_pkg.sv | 25 ++
 rtl/ram_port_arbiter_rr_arbiter2.sv | 31 +++
 rtl/ram_port_arbiter.sv | 100 ++++++++++
 tb/tb_ram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arb_pkg
// Description : Shared types and default widths for the RAM port arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 13;
    localparam int RAM_DATA_W = 32;

    // Outstanding access: the one issued last cycle whose ack is due now
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OUT_M0 = 2'd1,
        OUT_M1 = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-input combinational round-robin picker. On a conflict the
//               requester not named by i_last_grant wins.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_eligible,
    input  req_id_e    i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    // One-hot grant selection
    always_comb begin
        o_grant = 2'b00;
        case (i_eligible)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_last_grant == REQ_M1) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    assign o_valid = |i_eligible;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_port_arbiter
// Description : Shares a single-port RAM with 1-cycle registered read data
//               between instruction fetch (m0) and load/store (m1). One access
//               per cycle, round-robin on conflicts, ack + data one cycle
//               after issue.
// Revision    : 1.0  initial release
// ============================================================================
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    output logic                m0_ack_o,
    output logic [DATA_W-1:0]   m0_dat_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    output logic                m1_ack_o,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                ram_we_o,
    output logic [ADDR_W-1:0]   ram_adr_o,
    output logic [DATA_W/8-1:0] ram_be_o,
    output logic [DATA_W-1:0]   ram_dat_o,
    input  logic [DATA_W-1:0]   ram_dat_i
);

    arb_state_e r_state;
    req_id_e    r_last_grant;
    logic [1:0] w_eligible;
    logic [1:0] w_grant;
    logic       w_grant_valid;

    // A requester whose access is in its ack cycle is not re-issued, and
    // nothing is issued while reset is asserted.
    assign w_eligible[0] = !rst_i && m0_req_i && (r_state != OUT_M0);
    assign w_eligible[1] = !rst_i && m1_req_i && (r_state != OUT_M1);

    rr_arbiter2 u_rr (
        .i_eligible   (w_eligible),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_valid      (w_grant_valid)
    );

    // RAM port mirrors the granted requester, otherwise parks at zero
    always_comb begin
        ram_we_o  = 1'b0;
        ram_adr_o = '0;
        ram_be_o  = '0;
        ram_dat_o = '0;
        if (w_grant_valid && w_grant[0]) begin
            ram_we_o  = m0_we_i;
            ram_adr_o = m0_adr_i;
            ram_be_o  = m0_be_i;
            ram_dat_o = m0_dat_i;
        end else if (w_grant_valid && w_grant[1]) begin
            ram_we_o  = m1_we_i;
            ram_adr_o = m1_adr_i;
            ram_be_o  = m1_be_i;
            ram_dat_o = m1_dat_i;
        end
    end

    // Track the outstanding access and the round-robin history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_M1;
        end else if (w_grant_valid && w_grant[0]) begin
            r_state      <= OUT_M0;
            r_last_grant <= REQ_M0;
        end else if (w_grant_valid && w_grant[1]) begin
            r_state      <= OUT_M1;
            r_last_grant <= REQ_M1;
        end else begin
            r_state      <= IDLE;
        end
    end

    // Ack in the cycle the RAM's registered data is valid; reset in that
    // cycle discards the pending ack.
    assign m0_ack_o = (r_state == OUT_M0) && !rst_i;
    assign m1_ack_o = (r_state == OUT_M1) && !rst_i;
    assign m0_dat_o = m0_ack_o ? ram_dat_i : '0;
    assign m1_dat_o = m1_ack_o ? ram_dat_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Scoreboard bench for ram_port_arbiter with a behavioural RAM.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m0_we_i, m1_req_i, m1_we_i;
    logic [12:0] m0_adr_i, m1_adr_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic [31:0] m0_dat_i, m1_dat_i;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        ram_we_o;
    logic [12:0] ram_adr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_dat_o;
    logic [31:0] ram_dat_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic        we;
        logic [12:0] adr;
        logic [3:0]  be;
        logic [31:0] dat;
        logic [31:0] exp;
        logic        cmp;
        logic        ack;
        int          lat;
    } txn_t;

    txn_t q0[$], q1[$], e0[$], e1[$];
    txn_t t0, t1;
    int   log_id[$], log_cyc[$];

    ram_port_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_be_i(m0_be_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_be_i(m1_be_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .ram_we_o(ram_we_o), .ram_adr_o(ram_adr_o), .ram_be_o(ram_be_o),
        .ram_dat_o(ram_dat_o), .ram_dat_i(ram_dat_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural 8192x32 RAM: byte enables, registered read, old data on RDW
    logic [31:0] mem [8192];
    bit          written [8192];

    function automatic logic [31:0] cur_val(input logic [12:0] a);
        return written[a] ? mem[a] : (32'hC0DE0000 | {19'd0, a});
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk_i) begin
        ram_dat_i <= cur_val(ram_adr_o);
        if (ram_we_o) begin
            mem[ram_adr_o]     <= merge(cur_val(ram_adr_o), ram_dat_o, ram_be_o);
            written[ram_adr_o] <= 1'b1;
        end
    end

    function automatic txn_t mk(input logic we, input logic [12:0] adr, input logic [3:0] be,
                                input logic [31:0] dat, input logic [31:0] exp,
                                input logic cmp, input logic ack, input int lat);
        txn_t t;
        t.we = we; t.adr = adr; t.be = be; t.dat = dat;
        t.exp = exp; t.cmp = cmp; t.ack = ack; t.lat = lat;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Wait for the requester's ack; lat is cycles from presentation to ack
    task automatic await_ack(input int id, input int lat, input logic [12:0] adr);
        int  n;
        logic got;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk_i);
            n++;
            got = (id == 0) ? m0_ack_o : m1_ack_o;
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL m%0d_ack_timeout adr=%h: no ack in %0d cycles, expected ack", id, adr, n);
        end else if (lat >= 0 && (n - 1) != lat) begin
            fails++;
            $display("FAIL m%0d_latency adr=%h: got %0d cycles, expected %0d", id, adr, n - 1, lat);
        end
    endtask

    // m0 driver: one transaction at a time, held until its ack
    initial begin
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_adr_i = '0; m0_be_i = '0; m0_dat_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (q0.size() > 0) begin
                t0 = q0.pop_front();
                m0_req_i = 1'b1; m0_we_i = t0.we; m0_adr_i = t0.adr;
                m0_be_i = t0.be; m0_dat_i = t0.dat;
                if (t0.ack) begin
                    e0.push_back(t0);
                    await_ack(0, t0.lat, t0.adr);
                end
            end else begin
                m0_req_i = 1'b0;
            end
        end
    end

    // m1 driver
    initial begin
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_adr_i = '0; m1_be_i = '0; m1_dat_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (q1.size() > 0) begin
                t1 = q1.pop_front();
                m1_req_i = 1'b1; m1_we_i = t1.we; m1_adr_i = t1.adr;
                m1_be_i = t1.be; m1_dat_i = t1.dat;
                if (t1.ack) begin
                    e1.push_back(t1);
                    await_ack(1, t1.lat, t1.adr);
                end
            end else begin
                m1_req_i = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks data
    initial begin
        txn_t e;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (m0_ack_o && m1_ack_o) begin
                tests++; fails++;
                $display("FAIL dual_ack: both acks high at cycle %0d, expected one", cyc);
            end
            if (m0_ack_o) begin
                log_id.push_back(0); log_cyc.push_back(cyc);
                if (e0.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL m0_unexpected_ack: ack=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = e0.pop_front();
                    if (e.cmp) chk("m0_rdata", m0_dat_o, e.exp);
                    else chk("m0_ack", {31'd0, m0_ack_o}, 32'd1);
                end
            end else begin
                chk("m0_dat_idle", m0_dat_o, 32'd0);
            end
            if (m1_ack_o) begin
                log_id.push_back(1); log_cyc.push_back(cyc);
                if (e1.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL m1_unexpected_ack: ack=1 at cycle %0d, expected 0", cyc);
                end else begin
                    e = e1.pop_front();
                    if (e.cmp) chk("m1_rdata", m1_dat_o, e.exp);
                    else chk("m1_ack", {31'd0, m1_ack_o}, 32'd1);
                end
            end else begin
                chk("m1_dat_idle", m1_dat_o, 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 100 && !(q0.size() == 0 && q1.size() == 0 && e0.size() == 0 &&
                            e1.size() == 0 && !m0_req_i && !m1_req_i)) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) begin
            tests++; fails++;
            $display("FAIL idle_timeout: bench still busy after %0d cycles, expected idle", n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        // Reset with both requesters active: nothing may reach the RAM
        q0.push_back(mk(1'b1, 13'h0020, 4'hF, 32'h11111111, 32'h0, 1'b0, 1'b1, 4));
        q1.push_back(mk(1'b0, 13'h1FFF, 4'h0, 32'h0, 32'hC0DE1FFF, 1'b1, 1'b1, 5));
        repeat (3) begin
            @(posedge clk_i); #1;
            @(negedge clk_i);
            chk("rst_ram_we", {31'd0, ram_we_o}, 32'd0);
            chk("rst_ram_adr", {19'd0, ram_adr_o}, 32'd0);
            chk("rst_m0_ack", {31'd0, m0_ack_o}, 32'd0);
            chk("rst_m1_ack", {31'd0, m1_ack_o}, 32'd0);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("first_grant_adr", {19'd0, ram_adr_o}, 32'h20);
        chk("first_grant_we", {31'd0, ram_we_o}, 32'd1);
        chk("first_grant_dat", ram_dat_o, 32'h11111111);
        wait_idle();

        // m1 alone: partial write then read back
        q1.push_back(mk(1'b1, 13'h0010, 4'b0011, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 1));
        q1.push_back(mk(1'b0, 13'h0010, 4'h0, 32'h0, 32'hC0DEBEEF, 1'b1, 1'b1, 1));
        wait_idle();

        // Both streaming reads: strict alternation, m0 first
        log_id.delete(); log_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 13'h0000, 4'h0, 32'h0, 32'hC0DE0000, 1'b1, 1'b1, 1));
            q1.push_back(mk(1'b0, 13'h1FFF, 4'h0, 32'h0, 32'hC0DE1FFF, 1'b1, 1'b1, (i == 0) ? 2 : 1));
        end
        wait_idle();
        chk("il_count", log_id.size(), 32'd8);
        if (log_id.size() > 0) chk("il_first", log_id[0], 32'd0);
        for (int i = 1; i < log_id.size(); i++) begin
            chk("il_alternate", {31'd0, log_id[i] != log_id[i-1]}, 32'd1);
            chk("il_gap", log_cyc[i] - log_cyc[i-1], 32'd1);
        end

        // m0 held for 6 cycles alone: acks on every second cycle
        log_id.delete(); log_cyc.delete();
        for (int i = 0; i < 3; i++)
            q0.push_back(mk(1'b0, 13'h0020, 4'h0, 32'h0, 32'h11111111, 1'b1, 1'b1, 1));
        wait_idle();
        chk("hold_count", log_id.size(), 32'd3);
        for (int i = 1; i < log_id.size(); i++)
            chk("hold_gap", log_cyc[i] - log_cyc[i-1], 32'd2);

        // Same-address conflict: m1 write wins (last grant m0), m0 read sees new data
        q1.push_back(mk(1'b1, 13'h0100, 4'hF, 32'h12345678, 32'h0, 1'b0, 1'b1, 1));
        q0.push_back(mk(1'b0, 13'h0100, 4'h0, 32'h0, 32'h12345678, 1'b1, 1'b1, 2));
        wait_idle();

        // Reset in m1's ack cycle: ack dropped, write still lands
        q1.push_back(mk(1'b1, 13'h0200, 4'hF, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, -1));
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("rst_mid_we", {31'd0, ram_we_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_m1_ack", {31'd0, m1_ack_o}, 32'd0);
        chk("rst_mid_ram_we", {31'd0, ram_we_o}, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        wait_idle();
        q1.push_back(mk(1'b0, 13'h0200, 4'h0, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1, 1));
        wait_idle();

        repeat (2) @(negedge clk_i);
        chk("sb_empty_m0", e0.size(), 32'd0);
        chk("sb_empty_m1", e1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
